simmem_release_sched: RTL and testbench
=======================================

Name: simmem_release_sched

Overview:
- Per-slot delay scheduler that drives the release_en_i vector of one response bank (write-response or read-data instance).
- Each bank internal identifier (slot) is loaded with a delay from the delay calculator and counts down.
- Once the delay expires, the slot's release enable bit is raised and held until the bank reports that slot as released.
- Two instances are used in the memory simulator top level, one per bank, between the delay calculator and the response banks.

Parameters:
- NumSlots, 16, number of bank slots; equals the bank capacity (release_en width).
- SlotW, $clog2(NumSlots), width of a slot identifier.
- DelayW, 8, width of the delay field, in clock cycles.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- load_valid_i  in  1  delay load request valid.
- load_ready_o  out  1  load accepted when high together with load_valid_i.
- load_iid_i  in  SlotW  slot to arm.
- load_delay_i  in  DelayW  delay in ticks.
- tick_en_i  in  1  countdown enable; low freezes all counters (simulated stall).
- release_en_o  out  NumSlots  multi-hot release enable toward the bank.
- released_onehot_i  in  NumSlots  bank report of released slots, at most one bit per cycle.
- num_pending_o  out  SlotW+1  number of non-IDLE slots.
- err_o  out  1  sticky protocol error; see Optional Feature.

Behaviour:
- Reset:
  - On a clock edge with rst_i high, all slots go to IDLE and all counters clear.
  - release_en_o=0, num_pending_o=0, err_o=0, load_ready_o=0 during the reset cycle.
  - Reset mid-operation discards all pending delays; no release_en bit survives.
- Per-slot FSM states: IDLE, COUNT, ELIG.
  - IDLE -> COUNT on accepted load with load_delay_i>=2; counter := load_delay_i-1.
  - IDLE -> ELIG on accepted load with load_delay_i of 0 or 1.
  - COUNT: counter decrements by 1 on each cycle with tick_en_i=1. On a tick with counter==1, counter goes to 0 and the slot moves to ELIG. With tick_en_i=0, the counter holds.
  - ELIG -> IDLE on the cycle released_onehot_i[slot]=1.
- Release timing:
  - Load accepted at cycle T with delay d>=1 and tick_en_i held high gives release_en_o[slot]=1 from cycle T+d (registered output).
  - d=0 behaves as d=1.
  - release_en_o[slot]=1 exactly while the slot is in ELIG, and drops the cycle after the release.
- Load handshake:
  - load_ready_o = !rst_i && slot[load_iid_i]==IDLE, combinational.
  - Accept = load_valid_i && load_ready_o.
  - A load to a COUNT or ELIG slot stalls; the requester holds valid, iid and delay stable.
- Simultaneous events:
  - Release of slot A and load of slot B in the same cycle are both performed.
  - Release of slot A and load of slot A in the same cycle: the load is not accepted (slot not IDLE that cycle) and is accepted the next cycle.
  - Multiple slots may reach ELIG in the same cycle; all their bits rise together.
- released_onehot_i bits for slots not in ELIG are ignored and cause no state change.
- num_pending_o:
  - Registered.
  - Count of slots in COUNT or ELIG after the current edge.
  - Range 0..NumSlots, never wraps.
- Counters never underflow; a COUNT slot always has counter>=1.

Optional Feature:
- Macro SIMMEM_RELEASE_SCHED_CHECK_EN.
- Defined:
  - err_o is set and held (until rst_i) when any of these occurs:
    - released_onehot_i has a bit set for a non-ELIG slot;
    - released_onehot_i has more than one bit set;
    - load_valid_i=1 while load_iid_i >= NumSlots.
  - The checks do not alter slot behaviour.
- Undefined: err_o tied to 0 and no check logic is synthesised.

Test Plan:
- Reset then idle 10 cycles -> release_en_o=0, num_pending_o=0, load_ready_o=1 for every iid.
- Load iid=3, d=5 at cycle T, tick_en_i=1 -> release_en_o=16'h0008 from T+5. Then released_onehot_i=16'h0008 at T+7 -> release_en_o=0 at T+8 and num_pending_o=0.
- Load iid=2, d=4; drop tick_en_i for 3 cycles starting at T+1 -> release_en_o[2] rises at T+7. Also load iid=9 with d=0 -> release_en_o[9] rises at T+1.
- Load iid=5, d=3, then reload iid=5 while it is in COUNT -> load_ready_o=0 until the release. Release and reload in the same cycle -> reload accepted the next cycle; new delay counted from that cycle.
- Load slots 0,1,2 with d=6,4,6 on consecutive cycles -> bits 1 then 0 and 2 rise at T+5, T+6, T+8. Assert rst_i at T+7 -> all outputs 0 at T+8 and no bit rises afterward.
- With SIMMEM_RELEASE_SCHED_CHECK_EN defined: released_onehot_i=16'h0040 while slot 6 is IDLE -> err_o=1 next cycle and held; slot states are unchanged.

Source files
------------

// File: rtl/simmem_release_sched.sv
// Per-slot delay scheduler driving the release enable vector of one response bank.
// Optional protocol checking (sticky err_o) is built when SIMMEM_RELEASE_SCHED_CHECK_EN is defined.
module simmem_release_sched #(
    parameter int unsigned NumSlots = 16,
    parameter int unsigned SlotW    = $clog2(NumSlots),
    parameter int unsigned DelayW   = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_valid_i,
    output logic                load_ready_o,
    input  logic [SlotW-1:0]    load_iid_i,
    input  logic [DelayW-1:0]   load_delay_i,
    input  logic                tick_en_i,
    output logic [NumSlots-1:0] release_en_o,
    input  logic [NumSlots-1:0] released_onehot_i,
    output logic [SlotW:0]      num_pending_o,
    output logic                err_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_ELIG
    } slot_state_e;

    slot_state_e       state_q [NumSlots];
    slot_state_e       state_d [NumSlots];
    logic [DelayW-1:0] cnt_q   [NumSlots];
    logic [DelayW-1:0] cnt_d   [NumSlots];
    logic [SlotW:0]    pend_q;
    logic [SlotW:0]    pend_d;
    logic              iid_in_range;
    logic              accept;

    assign iid_in_range = ({1'b0, load_iid_i} < (SlotW+1)'(NumSlots));

    always_comb begin
        load_ready_o = 1'b0;
        if (!rst_i && iid_in_range) begin
            load_ready_o = (state_q[load_iid_i] == ST_IDLE);
        end
        accept       = load_valid_i && load_ready_o;
        pend_d       = '0;
        release_en_o = '0;
        for (int unsigned i = 0; i < NumSlots; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    // A delay of 0 or 1 skips counting: eligible on the next cycle.
                    if (accept && (load_iid_i == SlotW'(i))) begin
                        if (load_delay_i > DelayW'(1)) begin
                            state_d[i] = ST_COUNT;
                            cnt_d[i]   = load_delay_i - DelayW'(1);
                        end else begin
                            state_d[i] = ST_ELIG;
                        end
                    end
                end
                ST_COUNT: begin
                    if (tick_en_i) begin
                        if (cnt_q[i] == DelayW'(1)) begin
                            state_d[i] = ST_ELIG;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] - DelayW'(1);
                        end
                    end
                end
                ST_ELIG: begin
                    if (released_onehot_i[i]) begin
                        state_d[i] = ST_IDLE;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
            if (state_d[i] != ST_IDLE) begin
                pend_d = pend_d + (SlotW+1)'(1);
            end
            release_en_o[i] = (state_q[i] == ST_ELIG);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NumSlots; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NumSlots; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pend_q <= pend_d;
        end
    end

    assign num_pending_o = pend_q;

`ifdef SIMMEM_RELEASE_SCHED_CHECK_EN
    logic err_q;
    logic err_d;

    // release_en_o mirrors the ELIG set, so it doubles as the legal-release mask.
    always_comb begin
        err_d = err_q;
        if ((|(released_onehot_i & ~release_en_o)) ||
            (|(released_onehot_i & (released_onehot_i - NumSlots'(1)))) ||
            (load_valid_i && !iid_in_range)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_simmem_release_sched.sv
// Randomized and directed bench for simmem_release_sched against a tick-counting reference model.
// Define SIMMEM_RELEASE_SCHED_CHECK_EN to also exercise the sticky protocol error output.
module tb_simmem_release_sched;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [3:0]  load_iid;
    logic [7:0]  load_delay;
    logic        tick_en;
    logic [15:0] release_en;
    logic [15:0] released;
    logic [4:0]  num_pending;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a slot is busy from its accepted load until released;
    // it becomes eligible once it has seen max(d,1)-1 enabled ticks after the load edge.
    bit m_busy  [N];
    int m_need  [N];
    int m_ticks [N];
    bit m_err;

    always #5 clk = ~clk;

    simmem_release_sched #(
        .NumSlots (16),
        .DelayW   (8)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .load_valid_i      (load_valid),
        .load_ready_o      (load_ready),
        .load_iid_i        (load_iid),
        .load_delay_i      (load_delay),
        .tick_en_i         (tick_en),
        .release_en_o      (release_en),
        .released_onehot_i (released),
        .num_pending_o     (num_pending),
        .err_o             (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_elig(int i);
        return m_busy[i] && (m_ticks[i] >= m_need[i]);
    endfunction

    task automatic model_edge();
        logic [15:0] elig_v;
        if (rst) begin
            for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
            m_err = 1'b0;
            return;
        end
        for (int i = 0; i < N; i++) elig_v[i] = m_elig(i);
        if (((released & ~elig_v) != 16'h0) || ($countones(released) > 1)) m_err = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (!m_busy[i]) begin
                if (load_valid && (int'(load_iid) == i)) begin
                    m_busy[i]  = 1'b1;
                    m_need[i]  = (load_delay <= 8'd1) ? 0 : int'(load_delay) - 1;
                    m_ticks[i] = 0;
                end
            end else if (elig_v[i]) begin
                if (released[i]) m_busy[i] = 1'b0;
            end else if (tick_en) begin
                m_ticks[i]++;
            end
        end
    endtask

    task automatic check_outputs();
        logic [15:0] exp_rel;
        int          exp_pend;
        exp_pend = 0;
        for (int i = 0; i < N; i++) begin
            exp_rel[i] = m_elig(i);
            if (m_busy[i]) exp_pend++;
        end
        check_eq("release_en", 32'(release_en), 32'(exp_rel));
        check_eq("num_pending", 32'(num_pending), 32'(exp_pend));
`ifdef SIMMEM_RELEASE_SCHED_CHECK_EN
        check_eq("err", 32'(err), 32'(m_err));
`else
        check_eq("err", 32'(err), 32'd0);
`endif
    endtask

    task automatic check_ready();
        #1;
        check_eq("load_ready", 32'(load_ready), 32'(!rst && !m_busy[load_iid]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic load(input int iid, input int d);
        load_valid = 1'b1;
        load_iid   = 4'(iid);
        load_delay = 8'(d);
        check_ready();
        cycle();
        load_valid = 1'b0;
    endtask

    task automatic release_one(input int iid);
        released = 16'h0;
        released[iid] = 1'b1;
        cycle();
        released = 16'h0;
    endtask

    initial begin
        int r;
        rst        = 1'b1;
        load_valid = 1'b0;
        load_iid   = '0;
        load_delay = '0;
        tick_en    = 1'b1;
        released   = '0;
        cycles(2);
        rst = 1'b0;
        cycles(10);
        check_eq("idle_rel", 32'(release_en), 32'h0);
        for (int i = 0; i < N; i++) begin
            load_iid = 4'(i);
            #1;
            check_eq("idle_ready", 32'(load_ready), 32'd1);
        end

        // iid 3, delay 5: eligible at T+5, released at T+7, gone at T+8.
        load(3, 5);
        cycles(3);
        check_eq("d5_early", 32'(release_en), 32'h0);
        cycle();
        check_eq("d5_rise", 32'(release_en), 32'h0008);
        cycle();
        release_one(3);
        check_eq("d5_drop", 32'(release_en), 32'h0);
        check_eq("d5_pend", 32'(num_pending), 32'd0);

        // iid 2, delay 4 with a three-cycle stall; then iid 9 with delay 0.
        load(2, 4);
        tick_en = 1'b0;
        cycles(3);
        tick_en = 1'b1;
        cycles(2);
        check_eq("stall_early", 32'(release_en[2]), 32'd0);
        cycle();
        check_eq("stall_rise", 32'(release_en[2]), 32'd1);
        load(9, 0);
        check_eq("d0_rise", 32'(release_en), 32'h0204);
        release_one(2);
        release_one(9);

        // Reload of a busy slot stalls; release and reload in one cycle defers the load.
        load(5, 3);
        load_valid = 1'b1;
        load_delay = 8'd7;
        check_ready();
        cycle();
        check_ready();
        cycle();
        check_eq("reload_elig", 32'(release_en), 32'h0020);
        released = 16'h0020;
        check_ready();
        check_eq("reload_blocked", 32'(load_ready), 32'd0);
        cycle();
        released = 16'h0;
        check_ready();
        check_eq("reload_ready", 32'(load_ready), 32'd1);
        cycle();
        load_valid = 1'b0;
        cycles(5);
        check_eq("reload_early", 32'(release_en[5]), 32'd0);
        cycle();
        check_eq("reload_rise", 32'(release_en), 32'h0020);
        release_one(5);

        // Staggered loads, then reset mid-flight.
        load(0, 6);
        load(1, 4);
        load(2, 6);
        cycles(2);
        check_eq("stag_b1", 32'(release_en), 32'h0002);
        cycle();
        check_eq("stag_b0", 32'(release_en), 32'h0003);
        rst = 1'b1;
        check_ready();
        cycle();
        check_eq("rst_rel", 32'(release_en), 32'h0);
        check_eq("rst_pend", 32'(num_pending), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            check_eq("post_rst_rel", 32'(release_en), 32'h0);
        end

        // Release report for an idle slot: flagged under checking, ignored otherwise.
        released = 16'h0040;
        cycle();
        released = 16'h0;
        cycle();
`ifdef SIMMEM_RELEASE_SCHED_CHECK_EN
        check_eq("err_held", 32'(err), 32'd1);
`endif
        check_eq("err_pend", 32'(num_pending), 32'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;

        for (int k = 0; k < 3000; k++) begin
            rst        = ($urandom_range(0, 199) == 0);
            tick_en    = ($urandom_range(0, 3) != 0);
            load_valid = $urandom_range(0, 1);
            load_iid   = 4'($urandom_range(0, 15));
            r          = $urandom_range(0, 15);
            if (r < 4) load_delay = 8'($urandom_range(0, 2));
            else if (r == 15) load_delay = 8'($urandom_range(0, 255));
            else load_delay = 8'($urandom_range(0, 20));
            released = 16'h0;
            r = $urandom_range(0, 15);
`ifdef SIMMEM_RELEASE_SCHED_CHECK_EN
            if (m_elig(r) && $urandom_range(0, 1) == 1) released[r] = 1'b1;
            if ($urandom_range(0, 299) == 0) released = 16'($urandom);
`else
            if ((m_elig(r) || $urandom_range(0, 3) == 0) && $urandom_range(0, 1) == 1) released[r] = 1'b1;
`endif
            check_ready();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
